txpippm_pulse_sequencer: RTL and testbench
==========================================

TXPIPPM_PULSE_SEQUENCER -- requirements
Module: txpippm_pulse_sequencer

Interface
REQ-001 Parameter CHANNEL_COUNT, default 10, number of transceiver channels.
REQ-002 Parameter COUNT_WIDTH, default 16, width of the step-count field.
REQ-003 Parameter INTERVAL_WIDTH, default 16, width of the pulse-interval field.
REQ-004 Parameter PULSE_HIGH_CYCLES, default 4, pulse high time in clocks; must be >= 2.
REQ-005 gtwiz_userclk_tx_usrclk_in  in  1  TXUSRCLK; the only clock; all logic on its rising edge.
REQ-006 reset_in  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid_in  in  1  command valid.
REQ-008 cmd_ready_out  out  1  command accepted when valid and ready are both high on a clock edge.
REQ-009 cmd_sel_in  in  CHANNEL_COUNT  per-channel select mask for the command.
REQ-010 cmd_stepsize_in  in  5  PPM step size and direction code, passed through unmodified.
REQ-011 cmd_count_in  in  COUNT_WIDTH  number of PPM pulses to issue.
REQ-012 cmd_interval_in  in  INTERVAL_WIDTH  clocks from one pulse rising edge to the next.
REQ-013 abort_in  in  1  stop the command at the next pulse boundary.
REQ-014 sel_out  out  CHANNEL_COUNT  drives the downstream PPM controller sel_in.
REQ-015 pulse_out  out  1  drives the downstream PPM controller pulse_in.
REQ-016 stepsize_out  out  5  drives the downstream PPM controller stepsize_in.
REQ-017 busy_out  out  1  high while a command is executing.
REQ-018 done_out  out  1  one-cycle completion strobe.
REQ-019 aborted_out  out  1  qualifies done_out: high when the command ended by abort.
REQ-020 steps_issued_out  out  COUNT_WIDTH  pulses completed for the current or last command.

Function
REQ-021 The state machine SHALL have three states: IDLE, HIGH, LOW. All outputs SHALL be registered.
REQ-022 cmd_ready_out SHALL equal (state == IDLE).
- On acceptance, latch sel, stepsize and count.
- Latch the effective interval as max(cmd_interval_in, 2*PULSE_HIGH_CYCLES).
- Clear steps_issued_out.
REQ-023 Acceptance with count = 0 SHALL:
- stay in IDLE;
- issue no pulse;
- assert done_out for the next cycle, with aborted_out = 0.
REQ-024 Acceptance with count > 0 SHALL enter HIGH in the next cycle.
REQ-025 In HIGH, pulse_out SHALL be 1 for exactly PULSE_HIGH_CYCLES cycles, then the state SHALL move to LOW and steps_issued_out SHALL increment by 1.
REQ-026 LOW SHALL last (interval - PULSE_HIGH_CYCLES) cycles with pulse_out = 0. At its end:
- if steps_issued_out < count and no abort is pending, return to HIGH;
- otherwise go to IDLE.
REQ-027 The pulse rising-edge spacing SHALL equal the effective interval exactly, with no drift between pulses.
REQ-028 sel_out and stepsize_out SHALL hold the latched values for the whole of HIGH and LOW.
REQ-029 In IDLE, sel_out SHALL be all zeros and pulse_out SHALL be 0; stepsize_out SHALL hold its last value.
REQ-030 busy_out SHALL be 1 in HIGH and LOW and 0 in IDLE.
REQ-031 done_out SHALL be 1 for exactly the first IDLE cycle after LOW.
- aborted_out SHALL be valid in the same cycle and hold until the next acceptance.
REQ-032 abort_in pulses while busy SHALL be latched as pending.
- A pending abort SHALL never truncate a HIGH or LOW phase.
- It SHALL only suppress further pulses.
- aborted_out = 1 only if at least one pulse was suppressed.
REQ-033 abort_in in IDLE SHALL be ignored, including when it coincides with acceptance. A pending abort SHALL clear on entry to IDLE.
REQ-034 Counters SHALL be sized to their fields and never wrap.
- Maximum count = 2^COUNT_WIDTH - 1.
- Maximum interval = 2^INTERVAL_WIDTH - 1.
REQ-035 cmd_* inputs SHALL be ignored while busy; later commands wait until ready.

Reset
REQ-036 While reset_in is high, the block SHALL force, asynchronously:
- state = IDLE;
- pulse_out = 0, sel_out = 0, stepsize_out = 0;
- busy_out = 0, done_out = 0, aborted_out = 0;
- steps_issued_out = 0;
- pending abort cleared.
REQ-037 Reset asserted mid-pulse SHALL drop pulse_out immediately and discard the command; no done_out SHALL follow.
REQ-038 Deassertion SHALL be synchronised to gtwiz_userclk_tx_usrclk_in externally; the first command is acceptable on the first clock after release.

Verification
REQ-039 Basic command:
- Stimulus: count=3, interval=10, sel=0x005, stepsize=0x13, accepted at cycle 0.
- Required: pulse_out high cycles 1-4, 11-14, 21-24; sel_out=0x005 on cycles 1-30; done_out at cycle 31; steps_issued_out=3.
REQ-040 Interval clamp:
- Stimulus: interval=3, count=2, PULSE_HIGH_CYCLES=4.
- Required: rising edges 8 cycles apart; done_out 16 cycles after the first rise.
REQ-041 Zero count:
- Stimulus: count=0.
- Required: no pulse; done_out one cycle after acceptance; aborted_out=0; busy_out never 1.
REQ-042 Abort:
- Stimulus: count=5, interval=10, abort_in pulsed at cycle 6.
- Required: pulses only at cycles 1-4; done_out at cycle 11; aborted_out=1; steps_issued_out=1.
REQ-043 Reset mid-operation:
- Stimulus: reset_in asserted during the second HIGH phase.
- Required: all outputs zero immediately; no done_out; next command runs normally from steps_issued_out=0.
REQ-044 Back-pressure:
- Stimulus: cmd_valid_in held high with a second command during busy.
- Required: cmd_ready_out=0 until IDLE; the second command is accepted on the done_out cycle.

Source files
------------

// File: rtl/txpippm_pulse_sequencer.sv
// Command-driven PPM pulse sequencer for the TX phase-interpolator controller.
// Issues a programmed number of fixed-width pulses at a fixed rising-edge interval.
module txpippm_pulse_sequencer #(
  parameter int CHANNEL_COUNT     = 10,
  parameter int COUNT_WIDTH       = 16,
  parameter int INTERVAL_WIDTH    = 16,
  parameter int PULSE_HIGH_CYCLES = 4
) (
  input  logic                      gtwiz_userclk_tx_usrclk_in,
  input  logic                      reset_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [CHANNEL_COUNT-1:0]  cmd_sel_in,
  input  logic [4:0]                cmd_stepsize_in,
  input  logic [COUNT_WIDTH-1:0]    cmd_count_in,
  input  logic [INTERVAL_WIDTH-1:0] cmd_interval_in,
  input  logic                      abort_in,
  output logic [CHANNEL_COUNT-1:0]  sel_out,
  output logic                      pulse_out,
  output logic [4:0]                stepsize_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      aborted_out,
  output logic [COUNT_WIDTH-1:0]    steps_issued_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [INTERVAL_WIDTH-1:0] MIN_INTERVAL = INTERVAL_WIDTH'(2 * PULSE_HIGH_CYCLES);
  localparam logic [INTERVAL_WIDTH-1:0] HIGH_LAST    = INTERVAL_WIDTH'(PULSE_HIGH_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [INTERVAL_WIDTH-1:0] phase_q, phase_d;
  logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [COUNT_WIDTH-1:0]    steps_q, steps_d;
  logic [CHANNEL_COUNT-1:0]  sel_q, sel_d;
  logic [4:0]                stepsize_q, stepsize_d;
  logic                      pulse_q, pulse_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic                      ready_q, ready_d;
  logic                      abort_pend_q, abort_pend_d;
  logic                      abort_seen_s;

  // Next-state and next-output computation; phase_q counts from each rising edge so pulses never drift.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    interval_d   = interval_q;
    count_d      = count_q;
    steps_d      = steps_q;
    sel_d        = sel_q;
    stepsize_d   = stepsize_q;
    pulse_d      = pulse_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    ready_d      = ready_q;
    abort_pend_d = abort_pend_q;
    abort_seen_s = abort_pend_q | abort_in;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (cmd_valid_in) begin
          stepsize_d = cmd_stepsize_in;
          count_d    = cmd_count_in;
          interval_d = (cmd_interval_in < MIN_INTERVAL) ? MIN_INTERVAL : cmd_interval_in;
          steps_d    = {COUNT_WIDTH{1'b0}};
          aborted_d  = 1'b0;
          phase_d    = {INTERVAL_WIDTH{1'b0}};
          if (cmd_count_in == {COUNT_WIDTH{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d = HIGH;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            sel_d   = cmd_sel_in;
          end
        end else begin
          sel_d = {CHANNEL_COUNT{1'b0}};
        end
      end
      HIGH: begin
        abort_pend_d = abort_seen_s;
        phase_d      = phase_q + INTERVAL_WIDTH'(1);
        if (phase_q == HIGH_LAST) begin
          state_d = LOW;
          pulse_d = 1'b0;
          steps_d = steps_q + COUNT_WIDTH'(1);
        end else begin
          pulse_d = 1'b1;
        end
      end
      LOW: begin
        abort_pend_d = abort_seen_s;
        if (phase_q == interval_q - INTERVAL_WIDTH'(1)) begin
          phase_d = {INTERVAL_WIDTH{1'b0}};
          if ((steps_q < count_q) && !abort_seen_s) begin
            state_d = HIGH;
            pulse_d = 1'b1;
          end else begin
            // Only an abort can end the command with pulses still owed.
            state_d      = IDLE;
            busy_d       = 1'b0;
            ready_d      = 1'b1;
            sel_d        = {CHANNEL_COUNT{1'b0}};
            done_d       = 1'b1;
            aborted_d    = (steps_q < count_q);
            abort_pend_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + INTERVAL_WIDTH'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        pulse_d      = 1'b0;
        busy_d       = 1'b0;
        ready_d      = 1'b1;
        sel_d        = {CHANNEL_COUNT{1'b0}};
        abort_pend_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      phase_q      <= {INTERVAL_WIDTH{1'b0}};
      interval_q   <= MIN_INTERVAL;
      count_q      <= {COUNT_WIDTH{1'b0}};
      steps_q      <= {COUNT_WIDTH{1'b0}};
      sel_q        <= {CHANNEL_COUNT{1'b0}};
      stepsize_q   <= 5'd0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ready_q      <= 1'b1;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      interval_q   <= interval_d;
      count_q      <= count_d;
      steps_q      <= steps_d;
      sel_q        <= sel_d;
      stepsize_q   <= stepsize_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      ready_q      <= ready_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign cmd_ready_out    = ready_q;
  assign sel_out          = sel_q;
  assign pulse_out        = pulse_q;
  assign stepsize_out     = stepsize_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign aborted_out      = aborted_q;
  assign steps_issued_out = steps_q;

endmodule

// File: tb/tb_txpippm_pulse_sequencer.sv
// Randomised self-checking bench for txpippm_pulse_sequencer against a
// closed-form per-cycle timing model of each command.
module tb_txpippm_pulse_sequencer;

  localparam int CH = 10;
  localparam int CW = 16;
  localparam int IW = 16;
  localparam int PH = 4;

  typedef struct {
    int          n;
    int          ivl;
    int          ab;
    logic [CH-1:0] sel;
    logic [4:0]  st;
    bit          b2b;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [CH-1:0] cmd_sel_in;
  logic [4:0]    cmd_stepsize_in;
  logic [CW-1:0] cmd_count_in;
  logic [IW-1:0] cmd_interval_in;
  logic          abort_in;
  logic [CH-1:0] sel_out;
  logic          pulse_out;
  logic [4:0]    stepsize_out;
  logic          busy_out;
  logic          done_out;
  logic          aborted_out;
  logic [CW-1:0] steps_issued_out;

  int   errors = 0;
  int   checks = 0;
  cmd_t q[$];

  txpippm_pulse_sequencer #(
    .CHANNEL_COUNT(CH), .COUNT_WIDTH(CW), .INTERVAL_WIDTH(IW), .PULSE_HIGH_CYCLES(PH)
  ) dut (
    .gtwiz_userclk_tx_usrclk_in(clk),
    .reset_in(rst),
    .cmd_valid_in(cmd_valid_in),
    .cmd_ready_out(cmd_ready_out),
    .cmd_sel_in(cmd_sel_in),
    .cmd_stepsize_in(cmd_stepsize_in),
    .cmd_count_in(cmd_count_in),
    .cmd_interval_in(cmd_interval_in),
    .abort_in(abort_in),
    .sel_out(sel_out),
    .pulse_out(pulse_out),
    .stepsize_out(stepsize_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .aborted_out(aborted_out),
    .steps_issued_out(steps_issued_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int n, input int ivl, input int ab,
                              input logic [CH-1:0] sel, input logic [4:0] st, input bit b2b);
    cmd_t c;
    c.n = n; c.ivl = ivl; c.ab = ab; c.sel = sel; c.st = st; c.b2b = b2b;
    return c;
  endfunction

  function automatic int eff_ivl(input int ivl);
    return (ivl < 2 * PH) ? 2 * PH : ivl;
  endfunction

  task automatic drive_cmd(input cmd_t c, input logic v);
    cmd_valid_in    = v;
    cmd_sel_in      = c.sel;
    cmd_stepsize_in = c.st;
    cmd_count_in    = CW'(c.n);
    cmd_interval_in = IW'(c.ivl);
  endtask

  task automatic check_idle(input int steps, input bit ab, input bit done);
    check("idle_pulse", 32'(pulse_out), 32'd0);
    check("idle_busy", 32'(busy_out), 32'd0);
    check("idle_sel", 32'(sel_out), 32'd0);
    check("idle_ready", 32'(cmd_ready_out), 32'd1);
    check("done", 32'(done_out), 32'(done));
    check("aborted", 32'(aborted_out), 32'(ab));
    check("steps_final", 32'(steps_issued_out), 32'(steps));
  endtask

  // Runs command q[i] from a negedge in IDLE; pulse p of n rises at cycle 1+p*I after acceptance.
  task automatic run_cmd(input int i);
    cmd_t c;
    cmd_t junk;
    int   iv, n, d, j, p, o;
    bit   ab_exp, chain;
    c     = q[i];
    iv    = eff_ivl(c.ivl);
    n     = c.n;
    if (c.ab >= 1 && ((c.ab - 1) / iv + 1) < n) n = (c.ab - 1) / iv + 1;
    d      = (c.n == 0) ? 1 : n * iv + 1;
    ab_exp = (n < c.n);
    chain  = c.b2b && (i + 1 < q.size());
    drive_cmd(c, 1'b1);
    abort_in = (c.ab == 0);
    check("ready_acc", 32'(cmd_ready_out), 32'd1);
    for (int k = 1; k <= d; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == d) begin
        check_idle(n, ab_exp, 1'b1);
      end else begin
        j = k - 1;
        p = j / iv;
        o = j % iv;
        check("pulse", 32'(pulse_out), 32'(o < PH));
        check("busy", 32'(busy_out), 32'd1);
        check("ready_busy", 32'(cmd_ready_out), 32'd0);
        check("sel", 32'(sel_out), 32'(c.sel));
        check("stepsize", 32'(stepsize_out), 32'(c.st));
        check("done_busy", 32'(done_out), 32'd0);
        check("aborted_busy", 32'(aborted_out), 32'd0);
        check("steps", 32'(steps_issued_out), 32'(p + ((o >= PH) ? 1 : 0)));
      end
      abort_in = (k == c.ab);
      if (k == 1) begin
        if (chain) begin
          drive_cmd(q[i + 1], 1'b1);
        end else begin
          junk = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 30)), -1,
                    CH'($urandom), 5'($urandom), 1'b0);
          drive_cmd(junk, 1'b0);
        end
      end
    end
    if (!chain) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        @(posedge clk);
        @(negedge clk);
        abort_in     = 1'b0;
        cmd_valid_in = 1'b0;
        check_idle(n, ab_exp, 1'b0);
      end
    end
  endtask

  // Reset asserted during the second HIGH phase of a 3-pulse command.
  task automatic reset_midway();
    drive_cmd(mk(3, 10, -1, 10'h2AA, 5'h0A, 1'b0), 1'b1);
    abort_in = 1'b0;
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("pulse_pre_rst", 32'(pulse_out), 32'd1);
    rst = 1'b1;
    #1;
    check_idle(0, 1'b0, 1'b0);
    check("rst_stepsize", 32'(stepsize_out), 32'd0);
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle(0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle(0, 1'b0, 1'b0);
  endtask

  initial begin
    int   n, iv;
    rst = 1'b1;
    abort_in = 1'b0;
    drive_cmd(mk(0, 0, -1, '0, 5'd0, 1'b0), 1'b0);

    q.push_back(mk(3, 10, -1, 10'h005, 5'h13, 1'b0));
    q.push_back(mk(2, 3, -1, 10'h3FF, 5'h01, 1'b0));
    q.push_back(mk(0, 10, 0, 10'h155, 5'h1F, 1'b0));
    q.push_back(mk(5, 10, 6, 10'h0F0, 5'h07, 1'b1));
    q.push_back(mk(2, 9, -1, 10'h201, 5'h10, 1'b1));
    q.push_back(mk(1, 8, -1, 10'h0AA, 5'h02, 1'b0));
    for (int r = 0; r < 24; r++) begin
      n  = int'($urandom_range(0, 4));
      iv = int'($urandom_range(0, 20));
      q.push_back(mk(n, iv,
                     ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, n * eff_ivl(iv) + 1)),
                     CH'($urandom), 5'($urandom), 1'($urandom_range(0, 1))));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle(0, 1'b0, 1'b0);
    check("rst_stepsize0", 32'(stepsize_out), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < q.size(); i++) begin
      if (i == 6) reset_midway();
      run_cmd(i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
